im_fetch_ctrl: RTL and testbench
================================

IM_FETCH_CTRL -- requirements
Module: im_fetch_ctrl

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, SHALL be the first fetch PC after reset.
REQ-002 Parameter IM_WORDS, default 1024, SHALL be the instruction memory depth in words.
REQ-003 Parameter BUF_DEPTH, default 2, SHALL be the fetch buffer depth in entries.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 im_addr  out  32  SHALL be the byte address to instruction memory; the memory indexes it with bits [11:2].
REQ-007 im_data  in  32  SHALL be the instruction word, returned combinationally for im_addr in the same cycle.
REQ-008 redirect_valid  in  1  SHALL be the branch/jump redirect strobe.
REQ-009 redirect_pc  in  32  SHALL be the redirect target byte address.
REQ-010 inst_valid  out  1  SHALL indicate that the buffer head holds a valid instruction.
REQ-011 inst_ready  in  1  SHALL be asserted by decode to accept the head.
REQ-012 inst_data  out  32  SHALL be the head instruction word.
REQ-013 inst_pc  out  32  SHALL be the head instruction PC.
REQ-014 fetch_fault  out  1  SHALL indicate that the FAULT state is active.
REQ-015 fault_pc  out  32  SHALL hold the PC that caused the fault.

Function
REQ-016 States SHALL be RUN and FAULT; fetch_pc register; buffer of BUF_DEPTH {pc, inst} entries.
REQ-017 im_addr SHALL equal fetch_pc at all times.
REQ-018 In RUN, a push SHALL occur when in-range and (buffer not full OR a pop occurs this cycle): enqueue {fetch_pc, im_data}, fetch_pc += 4 (mod 2^32).
REQ-019 A pop SHALL occur when inst_valid && inst_ready; the head SHALL advance at the edge.
REQ-020 Simultaneous push and pop on a full buffer SHALL keep occupancy unchanged with no loss.
REQ-021 inst_valid SHALL be 1 exactly when occupancy > 0; inst_data/inst_pc SHALL be stable while valid && !ready.
REQ-022 In-range SHALL mean (fetch_pc - PC_RESET) < IM_WORDS*4, unsigned.
REQ-023 In RUN with fetch_pc out of range: no push; next state FAULT; fault_pc <= fetch_pc; buffered entries remain poppable.
REQ-024 FAULT SHALL perform no pushes; it SHALL be exited only by a redirect.
REQ-025 redirect_valid SHALL have priority over push and pop: at the edge flush buffer (occupancy 0), no push, pop ignored, fetch_pc <= redirect_pc.
REQ-026 A redirect with redirect_pc[1:0] != 0 SHALL flush, enter FAULT, and set fault_pc <= redirect_pc.
REQ-027 An aligned redirect SHALL enter RUN and clear fetch_fault.
REQ-028 Latency: a redirect at edge N SHALL make inst_valid=1 with inst_pc=redirect_pc after edge N+1.
REQ-029 Steady state with inst_ready held at 1 SHALL deliver one instruction per cycle.

Reset
REQ-030 While reset_n=0: fetch_pc=PC_RESET, state=RUN, occupancy=0, inst_valid=0, fetch_fault=0, fault_pc=0, inst_data=0, inst_pc=0.
REQ-031 Reset mid-operation SHALL discard all buffered entries and any pending fault immediately (asynchronous).
REQ-032 The first push SHALL occur at the first rising edge after reset_n deasserts.

Structure
REQ-033 The shared package im_pkg SHALL hold PC_RESET, IM_WORDS, the state encoding, and the fetch-entry record type.
REQ-034 Buffer storage and pointers SHALL be a sub-module im_fetch_fifo with push, pop, and flush inputs and full/empty outputs; im_fetch_ctrl SHALL hold the FSM, fetch_pc, and range check.

Verification
REQ-035 Reset release, ROM[0]=32'h3401_0001, inst_ready=1 -> after edge 1: inst_valid=1, inst_pc=0x3000, inst_data=32'h3401_0001; inst_pc advances by 4 per cycle.
REQ-036 inst_ready=0 for 5 cycles after reset -> occupancy saturates at 2; inst_pc held at 0x3000; after inst_ready=1, PCs 0x3000, 0x3004, 0x3008 appear with none skipped or duplicated.
REQ-037 Redirect to 0x3100 while full, with inst_ready=1 in the same cycle -> next cycle inst_valid=0; the following cycle inst_pc=0x3100.
REQ-038 Sequential fetch to 0x3FFC -> 0x3FFC delivered; next fetch_pc 0x4000 gives fetch_fault=1, fault_pc=0x4000, no further pushes.
REQ-039 Redirect to 0x3002 -> fetch_fault=1, fault_pc=0x3002, inst_valid=0; subsequent redirect to 0x3000 -> fetch_fault=0, inst_pc=0x3000 one edge later.
REQ-040 reset_n pulsed low mid-stream between edges -> inst_valid=0 immediately; after release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/im_pkg.sv
// im_pkg -- shared definitions for the instruction fetch controller.
// Holds the reset PC and instruction memory depth defaults, the fetch FSM
// state encoding, and the {pc, inst} record stored in the fetch buffer.
package im_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 1024;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/im_fetch_fifo.sv
// im_fetch_fifo -- circular buffer of fetched {pc, inst} entries.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   push, wr_entry   : enqueue request and the entry to enqueue
//   pop              : dequeue the head entry
//   flush            : empty the buffer; overrides push and pop
//   head             : current head entry (zero after reset)
//   full, empty      : occupancy status
// A push while full is accepted only when a pop happens in the same cycle,
// so occupancy stays at DEPTH with no entry lost.
module im_fetch_fifo
  import im_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with wrap, valid for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == CNT_W'(0));
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage, pointers and occupancy; flush dominates push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl -- sequential instruction fetch with a small decoupling buffer.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   im_addr / im_data           : instruction memory byte address / word
//   redirect_valid, redirect_pc : branch/jump redirect
//   inst_valid/ready/data/pc    : head-of-buffer handshake towards decode
//   fetch_fault, fault_pc       : fault state and the PC that caused it
// Fetching stops with a fault when fetch_pc leaves the instruction memory
// window or a redirect target is misaligned; only a redirect leaves FAULT.
module im_fetch_ctrl #(
  parameter logic [31:0] PC_RESET  = im_pkg::PC_RESET,
  parameter int unsigned IM_WORDS  = im_pkg::IM_WORDS,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  import im_pkg::*;

  localparam logic [31:0] IM_SPAN = 32'(IM_WORDS * 32'd4);

  fetch_state_e state_r;
  logic [31:0]  fetch_pc_r;
  logic [31:0]  fault_pc_r;
  logic [31:0]  pc_offset_s;
  logic         in_range_s;
  logic         pop_s;
  logic         push_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  fetch_entry_t wr_entry_s;
  fetch_entry_t head_s;

  // Range check, handshake and push decision; a redirect suppresses both.
  always_comb begin
    pc_offset_s = fetch_pc_r - PC_RESET;
    in_range_s  = (pc_offset_s < IM_SPAN);
    pop_s       = !fifo_empty_s && inst_ready && !redirect_valid;
    wr_entry_s  = '{pc: fetch_pc_r, inst: im_data};
    if (!redirect_valid && (state_r == ST_RUN) && in_range_s &&
        (!fifo_full_s || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  im_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .wr_entry (wr_entry_s),
    .head     (head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Fetch FSM: PC sequencing, redirects and fault capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_RUN;
      fetch_pc_r <= PC_RESET;
      fault_pc_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_r    <= ST_FAULT;
        fault_pc_r <= redirect_pc;
      end else begin
        state_r <= ST_RUN;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!in_range_s) begin
            state_r    <= ST_FAULT;
            fault_pc_r <= fetch_pc_r;
          end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
          end
        end
        ST_FAULT: state_r <= ST_FAULT;
        default:  state_r <= ST_FAULT;
      endcase
    end
  end

  assign im_addr     = fetch_pc_r;
  assign inst_valid  = !fifo_empty_s;
  assign inst_data   = head_s.inst;
  assign inst_pc     = head_s.pc;
  assign fetch_fault = (state_r == ST_FAULT);
  assign fault_pc    = fault_pc_r;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl -- self-checking bench for im_fetch_ctrl.
// A ROM model answers im_addr combinationally. A queue-based reference
// model tracks the expected buffer contents, fetch PC and fault state each
// cycle; directed tables and sequences cover the corner cases.
module tb_im_fetch_ctrl;

  localparam logic [31:0] PCR  = 32'h0000_3000;
  localparam logic [31:0] SPAN = 32'd4096;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic [31:0] rom [0:1023];

  always #5 clk = ~clk;

  assign im_data = rom[im_addr[11:2]];

  im_fetch_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_fault_pc;
  bit          m_fault;

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          exp_valid;
    logic [31:0] exp_pc;
    bit          exp_fault;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc      = PCR;
    m_fault    = 1'b0;
    m_fault_pc = 32'h0;
  endtask

  // One clock edge of the fetch rules, using the inputs now applied.
  task automatic model_step();
    bit          pop;
    bit          inr;
    logic [31:0] off;
    if (redirect_valid) begin
      mq.delete();
      m_fpc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        m_fault    = 1'b1;
        m_fault_pc = redirect_pc;
      end else begin
        m_fault = 1'b0;
      end
    end else begin
      pop = (mq.size() > 0) && inst_ready;
      off = m_fpc - PCR;
      inr = (off < SPAN);
      if (pop) void'(mq.pop_front());
      if (!m_fault) begin
        if (!inr) begin
          m_fault    = 1'b1;
          m_fault_pc = m_fpc;
        end else if (mq.size() < 2) begin
          mq.push_back('{pc: m_fpc, inst: rom[m_fpc[11:2]]});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("valid", 32'(inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_data", inst_data, mq[0].inst);
    end
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fault_pc);
    chk("im_addr", im_addr, m_fpc);
  endtask

  // Advance one edge, check #1 after it, return at the following negedge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; checks outputs while low.
  task automatic reset_pulse(input string tag);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'h0);
    chk({tag, "_fault_pc"}, fault_pc, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_inst_data"}, inst_data, 32'h0);
    chk({tag, "_im_addr"}, im_addr, PCR);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bit saw_end;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h3401_0001;

    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_im_addr", im_addr, PCR);
    chk("rst_inst_data", inst_data, 32'h0);
    reset_n = 1'b1;

    // Reset release with decode ready: one instruction per cycle.
    cycle();
    chk("first_pc", inst_pc, 32'h0000_3000);
    chk("first_data", inst_data, 32'h3401_0001);
    for (int k = 1; k < 4; k++) begin
      cycle();
      chk("stream_pc", inst_pc, PCR + 32'(4 * k));
      chk("stream_valid", 32'(inst_valid), 32'h1);
    end

    // Back-pressure, full-buffer redirect and misaligned-redirect table.
    tbl.push_back('{0, 32'h0,      0, 1, 32'h3000, 0});
    tbl.push_back('{0, 32'h0,      0, 1, 32'h3000, 0});
    tbl.push_back('{0, 32'h0,      0, 1, 32'h3000, 0});
    tbl.push_back('{0, 32'h0,      0, 1, 32'h3000, 0});
    tbl.push_back('{0, 32'h0,      0, 1, 32'h3000, 0});
    tbl.push_back('{0, 32'h0,      1, 1, 32'h3004, 0});
    tbl.push_back('{0, 32'h0,      1, 1, 32'h3008, 0});
    tbl.push_back('{0, 32'h0,      1, 1, 32'h300C, 0});
    tbl.push_back('{1, 32'h3100,   1, 0, 32'h0,    0});
    tbl.push_back('{0, 32'h0,      1, 1, 32'h3100, 0});
    tbl.push_back('{0, 32'h0,      1, 1, 32'h3104, 0});
    tbl.push_back('{1, 32'h3002,   1, 0, 32'h0,    1});
    tbl.push_back('{0, 32'h0,      1, 0, 32'h0,    1});
    tbl.push_back('{1, 32'h3000,   1, 0, 32'h0,    0});
    tbl.push_back('{0, 32'h0,      1, 1, 32'h3000, 0});
    tbl.push_back('{0, 32'h0,      1, 1, 32'h3004, 0});

    inst_ready = 1'b0;
    reset_pulse("midrst");
    for (int k = 0; k < tbl.size(); k++) begin
      redirect_valid = tbl[k].rv;
      redirect_pc    = tbl[k].rpc;
      inst_ready     = tbl[k].rdy;
      cycle();
      chk($sformatf("tbl%0d_valid", k), 32'(inst_valid), 32'(tbl[k].exp_valid));
      if (tbl[k].exp_valid) chk($sformatf("tbl%0d_pc", k), inst_pc, tbl[k].exp_pc);
      chk($sformatf("tbl%0d_fault", k), 32'(fetch_fault), 32'(tbl[k].exp_fault));
      if (k == 12) chk("mis_fault_pc", fault_pc, 32'h0000_3002);
    end
    redirect_valid = 1'b0;

    // Run off the end of instruction memory.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3F00;
    inst_ready     = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    saw_end = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (inst_valid && inst_pc == 32'h0000_3FFC) saw_end = 1'b1;
      if (fetch_fault && !inst_valid) break;
    end
    chk("end_delivered", 32'(saw_end), 32'h1);
    chk("end_fault", 32'(fetch_fault), 32'h1);
    chk("end_fault_pc", fault_pc, 32'h0000_4000);
    repeat (3) begin
      cycle();
      chk("end_no_push", 32'(inst_valid), 32'h0);
    end

    // Restart after a mid-stream reset clears the fault.
    reset_pulse("rst2");
    cycle();
    chk("restart_pc", inst_pc, 32'h0000_3000);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: redirect_pc = PCR + 32'(4 * $urandom_range(0, 1023));
        6:       redirect_pc = (PCR + 32'($urandom_range(0, 4095))) | 32'h1;
        7:       redirect_pc = 32'h0000_3FE0 + 32'(4 * $urandom_range(0, 7));
        8:       redirect_pc = $urandom & 32'hFFFF_FFFC;
        default: redirect_pc = PCR;
      endcase
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
